// File: rtl/vga_dither_out.sv
// ---------------------------------------------------------------------------
// vga_dither_out
//
// VGA output stage that narrows the core's per-channel colour to the width of
// a small resistor DAC. Instead of plain MSB truncation it can apply a 4x4
// ordered (Bayer) dither, either static or alternating every frame. Colour
// and syncs travel through the same two pix_ce-qualified stages, so they
// stay aligned at the pins.
//
// Ports:
//   clk_vga              VGA clock (only clock)
//   reset                synchronous, active-high reset
//   pix_ce               pixel clock enable; nothing advances while low
//   mode[1:0]            00 truncate, 01 static dither, 10 temporal dither,
//                        11 force black (latched at each vsync assert edge)
//   r_in/g_in/b_in       core colour, IN_BITS each
//   de_in                display enable (1 = active pixel)
//   hs_in/vs_in          core syncs (polarity set by SYNC_ACTIVE_LOW)
//   r_out/g_out/b_out    DAC colour, OUT_BITS each
//   hs_out/vs_out        syncs delayed to line up with the colour
// ---------------------------------------------------------------------------
module vga_dither_out #(
    parameter int IN_BITS         = 6,
    parameter int OUT_BITS        = 3,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                clk_vga,
    input  logic                reset,
    input  logic                pix_ce,
    input  logic [1:0]          mode,
    input  logic [IN_BITS-1:0]  r_in,
    input  logic [IN_BITS-1:0]  g_in,
    input  logic [IN_BITS-1:0]  b_in,
    input  logic                de_in,
    input  logic                hs_in,
    input  logic                vs_in,
    output logic [OUT_BITS-1:0] r_out,
    output logic [OUT_BITS-1:0] g_out,
    output logic [OUT_BITS-1:0] b_out,
    output logic                hs_out,
    output logic                vs_out
);

    localparam int   D         = IN_BITS - OUT_BITS;
    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [IN_BITS:0]    SAT_WIDE = (IN_BITS + 1)'((1 << OUT_BITS) - 1);
    localparam logic [OUT_BITS-1:0] SAT_OUT  = '1;

    generate
        if (OUT_BITS < 1 || OUT_BITS > IN_BITS || D > 4) begin : g_bad_params
            $fatal(1, "vga_dither_out: need 1 <= OUT_BITS <= IN_BITS and IN_BITS-OUT_BITS <= 4");
        end
    endgenerate

    // 4x4 ordered-dither matrix, indexed [y][x].
    function automatic logic [3:0] bayer(input logic [1:0] y, input logic [1:0] x);
        logic [3:0] v;
        case ({y, x})
            4'h0: v = 4'd0;   4'h1: v = 4'd8;   4'h2: v = 4'd2;   4'h3: v = 4'd10;
            4'h4: v = 4'd12;  4'h5: v = 4'd4;   4'h6: v = 4'd14;  4'h7: v = 4'd6;
            4'h8: v = 4'd3;   4'h9: v = 4'd11;  4'hA: v = 4'd1;   4'hB: v = 4'd9;
            4'hC: v = 4'd15;  4'hD: v = 4'd7;   4'hE: v = 4'd13;  default: v = 4'd5;
        endcase
        return v;
    endfunction

    // ---------------- Stage 1: input registers and raster counters ----------
    logic [IN_BITS-1:0] w_in_pix [3];
    logic [IN_BITS-1:0] r_s1_pix [3];
    logic               r_s1_de;
    logic               r_s1_hs;
    logic               r_s1_vs;
    logic [1:0]         r_xc;
    logic [1:0]         r_yc;
    logic               r_frame;
    logic [1:0]         r_mode;

    assign w_in_pix[0] = r_in;
    assign w_in_pix[1] = g_in;
    assign w_in_pix[2] = b_in;

    // The sample entering S1 is compared with the one already there, which is
    // the same as watching the S1 register go inactive -> active. Counters are
    // updated in the same clock so they always describe the pixel held in S1.
    logic w_hs_edge;
    logic w_vs_edge;
    assign w_hs_edge = (hs_in ^ SYNC_IDLE) & ~(r_s1_hs ^ SYNC_IDLE);
    assign w_vs_edge = (vs_in ^ SYNC_IDLE) & ~(r_s1_vs ^ SYNC_IDLE);

    always_ff @(posedge clk_vga) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) r_s1_pix[i] <= '0;
            r_s1_de <= 1'b0;
            r_s1_hs <= SYNC_IDLE;
            r_s1_vs <= SYNC_IDLE;
            r_xc    <= 2'd0;
            r_yc    <= 2'd0;
            r_frame <= 1'b0;
            r_mode  <= 2'b00;
        end else if (pix_ce) begin
            for (int i = 0; i < 3; i++) r_s1_pix[i] <= w_in_pix[i];
            r_s1_de <= de_in;
            r_s1_hs <= hs_in;
            r_s1_vs <= vs_in;
            // x advances after each active pixel leaves S1, so the first
            // active pixel after the hsync edge sees x = 0.
            if (w_hs_edge)    r_xc <= 2'd0;
            else if (r_s1_de) r_xc <= r_xc + 2'd1;
            if (w_vs_edge)      r_yc <= 2'd0;
            else if (w_hs_edge) r_yc <= r_yc + 2'd1;
            // Mode is only taken at frame start so a change never tears a frame.
            if (w_vs_edge) begin
                r_frame <= ~r_frame;
                r_mode  <= mode;
            end
        end
    end

    // ---------------- Stage 2: threshold, quantise, register ---------------
    logic [1:0] w_x_idx;
    logic [3:0] w_bayer;
    logic [3:0] w_thr;

    // Temporal mode mirrors the x index on odd frames.
    assign w_x_idx = (r_mode == 2'b10) ? (r_xc ^ {2{r_frame}}) : r_xc;
    assign w_bayer = bayer(r_yc, w_x_idx);
    assign w_thr   = w_bayer >> (4 - D);

    logic [3*OUT_BITS-1:0] w_out_bus;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            logic [IN_BITS:0]    w_sum;
            logic [IN_BITS:0]    w_dith;
            logic [OUT_BITS-1:0] w_trunc;
            logic [OUT_BITS-1:0] w_next;
            logic [OUT_BITS-1:0] r_out_ch;

            // One extra bit so in + t cannot wrap before saturation.
            assign w_sum   = {1'b0, r_s1_pix[gi]} + (IN_BITS + 1)'(w_thr);
            assign w_dith  = w_sum >> D;
            assign w_trunc = OUT_BITS'(r_s1_pix[gi] >> D);

            always_comb begin
                w_next = '0;
                if (r_s1_de) begin
                    case (r_mode)
                        2'b00:        w_next = w_trunc;
                        2'b01, 2'b10: w_next = (w_dith > SAT_WIDE) ? SAT_OUT
                                                                   : w_dith[OUT_BITS-1:0];
                        default:      w_next = '0;
                    endcase
                end
            end

            always_ff @(posedge clk_vga) begin
                if (reset)       r_out_ch <= '0;
                else if (pix_ce) r_out_ch <= w_next;
            end

            assign w_out_bus[gi*OUT_BITS +: OUT_BITS] = r_out_ch;
        end
    endgenerate

    logic r_hs_out;
    logic r_vs_out;

    always_ff @(posedge clk_vga) begin
        if (reset) begin
            r_hs_out <= SYNC_IDLE;
            r_vs_out <= SYNC_IDLE;
        end else if (pix_ce) begin
            r_hs_out <= r_s1_hs;
            r_vs_out <= r_s1_vs;
        end
    end

    assign r_out  = w_out_bus[0*OUT_BITS +: OUT_BITS];
    assign g_out  = w_out_bus[1*OUT_BITS +: OUT_BITS];
    assign b_out  = w_out_bus[2*OUT_BITS +: OUT_BITS];
    assign hs_out = r_hs_out;
    assign vs_out = r_vs_out;

endmodule

// File: tb/tb_vga_dither_out.sv
// ---------------------------------------------------------------------------
// tb_vga_dither_out
//
// Drives a small raster (24-pixel lines, 6-line frames) with random pix_ce
// gaps and random colours through vga_dither_out. Expected outputs are
// computed from raster position (active-pixel index in the line, line index
// in the frame, frame parity and the mode latched at frame start) and queued;
// a separate monitor pops one entry per pix_ce edge and compares.
// ---------------------------------------------------------------------------
module tb_vga_dither_out;

    localparam int IN_BITS  = 6;
    localparam int OUT_BITS = 3;
    localparam int D        = IN_BITS - OUT_BITS;
    localparam bit SAL      = 1'b1;
    localparam int MAXV     = (1 << OUT_BITS) - 1;

    logic                clk_vga = 1'b0;
    logic                reset;
    logic                pix_ce;
    logic [1:0]          mode;
    logic [IN_BITS-1:0]  r_in, g_in, b_in;
    logic                de_in, hs_in, vs_in;
    logic [OUT_BITS-1:0] r_out, g_out, b_out;
    logic                hs_out, vs_out;
    logic [OUT_BITS-1:0] ah_r, ah_g, ah_b;
    logic                ah_hs, ah_vs;

    always #5 clk_vga = ~clk_vga;

    vga_dither_out u_dut (
        .clk_vga(clk_vga), .reset(reset), .pix_ce(pix_ce), .mode(mode),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hs_out(hs_out), .vs_out(vs_out)
    );

    // Active-high sync build, used for its reset levels.
    vga_dither_out #(.SYNC_ACTIVE_LOW(1'b0)) u_dut_ah (
        .clk_vga(clk_vga), .reset(reset), .pix_ce(pix_ce), .mode(mode),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
        .r_out(ah_r), .g_out(ah_g), .b_out(ah_b),
        .hs_out(ah_hs), .vs_out(ah_vs)
    );

    typedef struct {
        logic [OUT_BITS-1:0] r, g, b;
        logic                hs, vs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int bayer_tbl [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    // Reference state: what the raster looks like from the outside.
    int m_mode, m_fpar, m_x, m_y;
    bit m_prev_hs, m_prev_vs;

    function automatic exp_t idle_exp();
        exp_t e;
        e.r = '0; e.g = '0; e.b = '0; e.hs = SAL; e.vs = SAL;
        return e;
    endfunction

    function automatic int chan_exp(int v, int md, int x, int y, int fp, bit de);
        int xi, t, s;
        if (!de || md == 3) return 0;
        if (md == 0) return v / (1 << D);
        xi = (md == 2 && fp == 1) ? (x ^ 3) : x;
        t  = bayer_tbl[y][xi] / (1 << (4 - D));
        s  = (v + t) / (1 << D);
        return (s > MAXV) ? MAXV : s;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(idle_exp());   // S1 contents right after reset
        m_mode = 0; m_fpar = 0; m_x = 0; m_y = 0;
        m_prev_hs = 1'b0; m_prev_vs = 1'b0;
    endtask

    task automatic send_pixel(input logic [IN_BITS-1:0] rv, gv, bv,
                              input bit de, hs_act, vs_act, input logic [1:0] md);
        bit   hs_edge, vs_edge;
        int   x_use, y_use;
        exp_t e;
        while ($urandom_range(0, 3) == 0) begin
            @(negedge clk_vga);
            pix_ce = 1'b0;
            r_in = IN_BITS'($urandom); g_in = IN_BITS'($urandom); b_in = IN_BITS'($urandom);
        end
        @(negedge clk_vga);
        pix_ce = 1'b1;
        r_in = rv; g_in = gv; b_in = bv; de_in = de;
        hs_in = hs_act ^ SAL; vs_in = vs_act ^ SAL; mode = md;
        hs_edge = hs_act && !m_prev_hs;
        vs_edge = vs_act && !m_prev_vs;
        if (vs_edge) begin
            m_mode = int'(md);
            m_fpar = 1 - m_fpar;
        end
        x_use = hs_edge ? 0 : m_x;
        y_use = vs_edge ? 0 : (hs_edge ? (m_y + 1) % 4 : m_y);
        m_x = (x_use + int'(de)) % 4;
        m_y = y_use;
        m_prev_hs = hs_act; m_prev_vs = vs_act;
        e.r  = OUT_BITS'(chan_exp(int'(rv), m_mode, x_use, y_use, m_fpar, de));
        e.g  = OUT_BITS'(chan_exp(int'(gv), m_mode, x_use, y_use, m_fpar, de));
        e.b  = OUT_BITS'(chan_exp(int'(bv), m_mode, x_use, y_use, m_fpar, de));
        e.hs = hs_act ^ SAL;
        e.vs = vs_act ^ SAL;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk_vga);
        reset  = 1'b1;
        pix_ce = 1'($urandom_range(0, 1));
        model_reset();
        @(negedge clk_vga);
        reset  = 1'b0;
        pix_ce = 1'b0;
    endtask

    // ---------------- Monitor ----------------
    initial begin
        exp_t last_exp;
        exp_t e;
        bit   rst_s, ce_s;
        int   npix;
        npix = 0;
        last_exp = idle_exp();
        forever begin
            @(posedge clk_vga);
            rst_s = reset;
            ce_s  = pix_ce;
            #1;
            if (rst_s) begin
                checks++;
                if (r_out !== '0 || g_out !== '0 || b_out !== '0 || hs_out !== SAL || vs_out !== SAL) begin
                    errors++;
                    $display("FAIL reset: got r=%0d g=%0d b=%0d hs=%0b vs=%0b, want 0 0 0 hs=%0b vs=%0b",
                             r_out, g_out, b_out, hs_out, vs_out, SAL, SAL);
                end
                checks++;
                if (ah_hs !== 1'b0 || ah_vs !== 1'b0 || ah_r !== '0) begin
                    errors++;
                    $display("FAIL reset_ah: got r=%0d hs=%0b vs=%0b, want 0 0 0", ah_r, ah_hs, ah_vs);
                end
                last_exp = idle_exp();
            end else if (ce_s) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL underflow: DUT advanced with no expected pixel queued");
                end else begin
                    e = exp_q.pop_front();
                    npix++;
                    if (r_out !== e.r || g_out !== e.g || b_out !== e.b || hs_out !== e.hs || vs_out !== e.vs) begin
                        errors++;
                        $display("FAIL pixel %0d: got r=%0d g=%0d b=%0d hs=%0b vs=%0b, want r=%0d g=%0d b=%0d hs=%0b vs=%0b",
                                 npix, r_out, g_out, b_out, hs_out, vs_out, e.r, e.g, e.b, e.hs, e.vs);
                    end else begin
                        $display("pixel %0d: r=%0d g=%0d b=%0d hs=%0b vs=%0b ok",
                                 npix, r_out, g_out, b_out, hs_out, vs_out);
                    end
                    last_exp = e;
                end
            end else begin
                checks++;
                if (r_out !== last_exp.r || g_out !== last_exp.g || b_out !== last_exp.b ||
                    hs_out !== last_exp.hs || vs_out !== last_exp.vs) begin
                    errors++;
                    $display("FAIL hold: got r=%0d g=%0d b=%0d hs=%0b vs=%0b, want r=%0d g=%0d b=%0d hs=%0b vs=%0b",
                             r_out, g_out, b_out, hs_out, vs_out,
                             last_exp.r, last_exp.g, last_exp.b, last_exp.hs, last_exp.vs);
                end
            end
        end
    end

    // ---------------- Watchdog ----------------
    initial begin
        #500000;
        $display("FAIL timeout: stimulus did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    // ---------------- Stimulus ----------------
    initial begin
        int start_mode [7] = '{0, 1, 2, 2, 3, 1, 2};
        int mid_mode   [7];
        logic [1:0]         cur_mode;
        logic [IN_BITS-1:0] rv, gv, bv;
        bit  hs_act, vs_act, de;
        int  pcount;

        mid_mode[0] = 1;   // 00 -> 01 mid-frame must not show until next frame
        for (int i = 1; i < 7; i++) mid_mode[i] = $urandom_range(0, 3);

        reset = 1'b1; pix_ce = 1'b0; mode = 2'b00;
        r_in = '0; g_in = '0; b_in = '0; de_in = 1'b0;
        hs_in = SAL; vs_in = SAL;
        cur_mode = 2'b00;
        pcount = 0;
        model_reset();
        repeat (3) @(negedge clk_vga);
        reset = 1'b0;

        for (int fr = 0; fr < 7; fr++) begin
            for (int ln = 0; ln < 6; ln++) begin
                for (int px = 0; px < 24; px++) begin
                    if (px == 0 && ln == 0) cur_mode = 2'(start_mode[fr]);
                    if (px == 0 && ln == 3) cur_mode = 2'(mid_mode[fr]);
                    if (fr == 5 && ln == 2 && px == 10) do_reset();
                    hs_act = (px < 4);
                    vs_act = (ln == 0);
                    de     = (px >= 6 && px < 22);
                    if (fr <= 3) rv = (ln == 1) ? 6'd63 : ((ln == 5) ? 6'd0 : 6'd20);
                    else         rv = IN_BITS'($urandom);
                    gv = IN_BITS'($urandom);
                    bv = IN_BITS'($urandom);
                    send_pixel(rv, gv, bv, de, hs_act, vs_act, cur_mode);
                    pcount++;
                    if (pcount % 150 == 75) begin
                        repeat (5) begin
                            @(negedge clk_vga);
                            pix_ce = 1'b0;
                            r_in = IN_BITS'($urandom);
                        end
                    end
                end
            end
        end

        repeat (3) send_pixel('0, '0, '0, 1'b0, 1'b0, 1'b0, cur_mode);
        repeat (4) begin
            @(negedge clk_vga);
            pix_ce = 1'b0;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
